// File: rtl/iir_decimator.sv
// iir_decimator: averages each block of 2^LOG2_DECIM valid samples from the IIR
// stage with round-half-up, then buffers the averages in a small
// first-word-fall-through FIFO. The IIR stage cannot stall, so a result that
// arrives while the FIFO is full is dropped and recorded in a sticky flag.
module iir_decimator #(
    parameter int LOG2_DECIM = 2,
    parameter int FIFO_AW    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         din,
    input  logic               din_valid,
    output logic [7:0]         dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               ovf
);

    localparam int ACC_W = 8 + LOG2_DECIM;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [LOG2_DECIM-1:0] CNT_LAST   = '1;
    localparam logic [FIFO_AW:0]      LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);
    // Half an LSB of the output, added before the shift to round half up.
    localparam logic signed [ACC_W:0] ROUND      = (ACC_W + 1)'(1 << (LOG2_DECIM - 1));

    logic signed [ACC_W-1:0] acc;
    logic [LOG2_DECIM-1:0]   cnt;
    logic signed [ACC_W:0]   sum_ext;
    logic [7:0]              result;
    logic                    push_req;
    logic                    push_ok;
    logic                    pop;
    logic                    full;

    logic [7:0]              mem [DEPTH];
    logic [FIFO_AW-1:0]      wr_ptr;
    logic [FIFO_AW-1:0]      rd_ptr;

    // Block sum including the current sample, rounded and scaled down by D.
    // One spare bit keeps the rounding add from wrapping at the positive limit.
    always_comb begin
        sum_ext  = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - 8){din[7]}}, din};
        result   = 8'((sum_ext + ROUND) >>> LOG2_DECIM);
        push_req = din_valid && (cnt == CNT_LAST);
        full     = (fifo_level == LEVEL_FULL);
        pop      = dout_valid && dout_ready;
        push_ok  = push_req && (!full || pop);
    end

    // Accumulate valid samples; clear at each block end whether or not the result fits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (din_valid) begin
            if (cnt == CNT_LAST) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum_ext[ACC_W-1:0];
                cnt <= cnt + 1'b1;
            end
        end
    end

    // FIFO storage, pointers, level and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            ovf        <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= result;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (pop && !push_ok) begin
                fifo_level <= fifo_level - 1'b1;
            end
            if (push_req && full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

    // Head of FIFO presented straight from storage; zero when nothing is buffered.
    always_comb begin
        dout_valid = (fifo_level != '0);
        dout       = dout_valid ? mem[rd_ptr] : 8'h00;
    end

endmodule

// File: tb/tb_iir_decimator.sv
// Directed bench for iir_decimator with D=4 and a 4-entry FIFO.
module tb_iir_decimator;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [2:0] fifo_level;
    logic       ovf;

    int n_checks = 0;
    int n_errors = 0;

    iir_decimator #(.LOG2_DECIM(2), .FIFO_AW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .fifo_level (fifo_level),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given input; returns 1 time unit after the edge.
    task automatic cyc(input logic [7:0] d, input logic v);
        din       = d;
        din_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic block4(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
        cyc(a, 1'b1);
        cyc(b, 1'b1);
        cyc(c, 1'b1);
        cyc(d, 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        din        = 8'h00;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        #2;
        chk("rst_dout_valid", dout_valid, 1'b0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_level", fifo_level, 3'd0);
        chk("rst_ovf", ovf, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic block of 10s, consumer ready
        dout_ready = 1'b1;
        cyc(8'd10, 1'b1);
        cyc(8'd10, 1'b1);
        cyc(8'd10, 1'b1);
        chk("basic_not_yet", dout_valid, 1'b0);
        cyc(8'd10, 1'b1);
        chk("basic_valid", dout_valid, 1'b1);
        chk("basic_dout", dout, 8'd10);
        chk("basic_level1", fifo_level, 3'd1);
        cyc(8'd0, 1'b0);
        chk("basic_popped", dout_valid, 1'b0);
        chk("basic_level0", fifo_level, 3'd0);

        // Rounding cases
        block4(8'd1, 8'd1, 8'd1, 8'd0);
        chk("round_3", dout, 8'd1);
        cyc(8'd0, 1'b0);
        block4(8'hFF, 8'hFF, 8'hFF, 8'hFE);
        chk("round_m5", dout, 8'hFF);
        cyc(8'd0, 1'b0);
        block4(8'd127, 8'd127, 8'd127, 8'd127);
        chk("round_max", dout, 8'd127);
        cyc(8'd0, 1'b0);
        block4(8'h80, 8'h80, 8'h80, 8'h80);
        chk("round_min", dout, 8'h80);
        cyc(8'd0, 1'b0);
        block4(8'd2, 8'd2, 8'd2, 8'hF9);
        chk("round_m1", dout, 8'd0);
        chk("round_m1_valid", dout_valid, 1'b1);
        cyc(8'd0, 1'b0);
        chk("round_level0", fifo_level, 3'd0);

        // Toggling din_valid; invalid-cycle data must be ignored
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) cyc(8'd5, 1'b1);
            else            cyc(8'd100, 1'b0);
            if (i == 5) chk("toggle_early", dout_valid, 1'b0);
            if (i == 6) begin
                chk("toggle_valid", dout_valid, 1'b1);
                chk("toggle_dout", dout, 8'd5);
            end
        end
        chk("toggle_drained", fifo_level, 3'd0);

        // Overflow: five blocks with no consumer
        dout_ready = 1'b0;
        block4(8'd1, 8'd1, 8'd1, 8'd1);
        block4(8'd2, 8'd2, 8'd2, 8'd2);
        block4(8'd3, 8'd3, 8'd3, 8'd3);
        block4(8'd4, 8'd4, 8'd4, 8'd4);
        chk("ovf_full_level", fifo_level, 3'd4);
        chk("ovf_not_yet", ovf, 1'b0);
        block4(8'd5, 8'd5, 8'd5, 8'd5);
        chk("ovf_level", fifo_level, 3'd4);
        chk("ovf_set", ovf, 1'b1);
        dout_ready = 1'b1;
        chk("ovf_pop1", dout, 8'd1);
        cyc(8'd0, 1'b0);
        chk("ovf_pop2", dout, 8'd2);
        cyc(8'd0, 1'b0);
        chk("ovf_pop3", dout, 8'd3);
        cyc(8'd0, 1'b0);
        chk("ovf_pop4", dout, 8'd4);
        cyc(8'd0, 1'b0);
        chk("ovf_drained", fifo_level, 3'd0);
        chk("ovf_empty_valid", dout_valid, 1'b0);
        chk("ovf_sticky", ovf, 1'b1);
        cyc(8'd0, 1'b0);
        chk("ovf_empty_dout", dout, 8'd0);

        // Clear ovf with an asynchronous reset between edges
        #3;
        rst = 1'b1;
        #1;
        chk("ovf_cleared", ovf, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full FIFO with push and pop on the same edge
        dout_ready = 1'b0;
        block4(8'd1, 8'd1, 8'd1, 8'd1);
        block4(8'd2, 8'd2, 8'd2, 8'd2);
        block4(8'd3, 8'd3, 8'd3, 8'd3);
        block4(8'd4, 8'd4, 8'd4, 8'd4);
        chk("pp_full", fifo_level, 3'd4);
        cyc(8'd6, 1'b1);
        cyc(8'd6, 1'b1);
        cyc(8'd6, 1'b1);
        dout_ready = 1'b1;
        cyc(8'd6, 1'b1);
        chk("pp_level", fifo_level, 3'd4);
        chk("pp_no_ovf", ovf, 1'b0);
        chk("pp_head", dout, 8'd2);
        cyc(8'd0, 1'b0);
        chk("pp_out3", dout, 8'd3);
        cyc(8'd0, 1'b0);
        chk("pp_out4", dout, 8'd4);
        cyc(8'd0, 1'b0);
        chk("pp_out6", dout, 8'd6);
        cyc(8'd0, 1'b0);
        chk("pp_drained", fifo_level, 3'd0);

        // Reset mid-block with data buffered
        dout_ready = 1'b0;
        block4(8'd3, 8'd3, 8'd3, 8'd3);
        cyc(8'd50, 1'b1);
        cyc(8'd50, 1'b1);
        chk("mid_buffered", dout_valid, 1'b1);
        din_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", dout_valid, 1'b0);
        chk("mid_rst_dout", dout, 8'd0);
        chk("mid_rst_level", fifo_level, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        dout_ready = 1'b1;
        block4(8'd8, 8'd8, 8'd8, 8'd8);
        chk("mid_after_valid", dout_valid, 1'b1);
        chk("mid_after_dout", dout, 8'd8);
        chk("mid_after_level", fifo_level, 3'd1);
        cyc(8'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iir_decimator.md
# iir_decimator

Accumulate-and-dump decimator sitting directly downstream of the IIR filter. Consumes the filter's 8-bit signed output stream, averages each block of 2^LOG2_DECIM valid samples with round-half-up, and buffers the results in a small first-word-fall-through FIFO with a valid/ready output handshake. Overflow of the FIFO is flagged stickily, not back-pressured, because the IIR stage cannot stall.

## Interface
- LOG2_DECIM, 2, log2 of decimation factor D; legal range 1..4 (D = 2..16)
- FIFO_AW, 2, FIFO address width; depth = 2^FIFO_AW (default 4 entries)
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high; clears all state immediately
- din  input  8  signed sample from IIR dout
- din_valid  input  1  din is a valid sample this cycle
- dout  output  8  signed decimated sample (FIFO head); 0 when dout_valid low
- dout_valid  output  1  FIFO non-empty
- dout_ready  input  1  consumer accepts dout this cycle
- fifo_level  output  FIFO_AW+1  number of stored results, 0..2^FIFO_AW
- ovf  output  1  sticky: a result was dropped because FIFO was full

## Operation
- Accumulator acc: signed, 8+LOG2_DECIM bits; sample counter cnt: LOG2_DECIM bits.
- din_valid=1 and cnt<D-1: acc <= acc + sext(din); cnt <= cnt+1.
- din_valid=1 and cnt=D-1 (block end): sum = acc + sext(din); result = (sum + 2^(LOG2_DECIM-1)) >>> LOG2_DECIM (arithmetic), truncated to 8 bits; acc <= 0; cnt <= 0; result pushed to FIFO at the same edge.
- Width rule: sum range [-128·D, 127·D]; rounded result range is exactly [-128, 127]; no saturation logic required, and none may alter values.
- din_valid=0: acc, cnt hold.
- FIFO: circular buffer, write pointer/read pointer of FIFO_AW bits plus level counter. Pop when dout_valid && dout_ready at the edge. Output order = push order.
- Push when full and no pop in same cycle: result discarded, FIFO unchanged, ovf <= 1 (held until rst). Accumulator restarts regardless.
- Push and pop same edge: both take effect; level unchanged; legal when full (no ovf) and when level=1.
- Pop when empty: impossible (dout_valid=0); dout_ready ignored.
- Pointers wrap modulo 2^FIFO_AW.

## Timing
- Reset values: dout=0, dout_valid=0, fifo_level=0, ovf=0, acc=0, cnt=0, pointers=0. Effect is immediate on rst rising (asynchronous), independent of clk.
- Reset mid-block: partial accumulation discarded; first block after release starts from cnt=0.
- Latency: block-end sample sampled at edge k -> if FIFO was empty, dout_valid=1 and dout=result after edge k (one edge, no extra pipeline).
- dout and dout_valid driven from registers/FIFO storage only; no combinational path from din or din_valid to any output. dout_ready affects only next-edge state.
- fifo_level and ovf update at the same edge as the push/pop causing them.
- Throughput: one block per D valid samples; continuous din_valid=1 yields one result every D cycles.

## Test plan
- Reset, then din=10 with din_valid=1 for 4 cycles, dout_ready=1 (D=4) -> dout_valid=1, dout=10 after 4th edge, popped next edge; fifo_level returns 0.
- Rounding: blocks {1,1,1,0} -> 1; {-1,-1,-1,-2} -> -1; {127×4} -> 127; {-128×4} -> -128; {2,2,2,-7} -> 0 (sum -1, +2 -> 1 >>> 2 = 0).
- din_valid toggling 1/0 with din=5 on valid cycles -> exactly one result (5) after the 4th valid sample; invalid-cycle din values (e.g. 100) have no effect.
- dout_ready=0, feed 5 blocks with values 1..5 -> fifo_level=4, ovf=1 after 5th block; then dout_ready=1 -> outputs 1,2,3,4 in order, level 0, ovf remains 1.
- FIFO full, dout_ready=1 on the same edge as a block end -> level stays 4, ovf stays 0, new result appears at tail in correct order.
- Feed 2 samples, assert rst asynchronously between edges -> all outputs 0 immediately; after release, block {8,8,8,8} -> dout=8 (no residue from earlier samples).
